vicii_sprite_dma: RTL

- Central sprite DMA scheduler for the VIC-II. It owns the per-line sprite fetch sequence for all 8 sprites:
  - Y-match DMA turn-on and turn-off.
  - MC/MCBASE counters and Y-expansion flip-flops.
  - BA (bus-available) generation.
  - p-access and s-access address generation.
  - Load strobes that steer fetched bytes into the per-sprite shift registers.
- Sits between the raster timing generator and the per-sprite pixel units, which become pure shifters/colour muxes.

---
 rtl/vicii_pkg.sv | 21 ++
 rtl/vicii_sprite_dma_if.sv | 23 ++
 rtl/vicii_sprite_ctr.sv | 68 ++++++
 rtl/vicii_sprite_dma.sv | 115 +++++++++++
 4 files changed

// File: rtl/vicii_pkg.sv
// rtl/vicii_pkg.sv - shared VIC-II line timing constants and sprite slot helpers
package vicii_pkg;

    localparam int CYCLES_PAL = 63;
    localparam int SPR_P0     = 58;
    localparam int SPR_ON     = 55;
    localparam int SPR_ADV    = 15;
    localparam int NSPR       = 8;

    localparam logic [13:0] IDLE_ADDR = 14'h3FFF;

    // Constant-only helper: cycle offset with wrap across the line end.
    function automatic logic [5:0] cyc_add(input int c, input int d);
        return 6'((c + d + CYCLES_PAL) % CYCLES_PAL);
    endfunction

    function automatic logic [5:0] spr_slot(input int n);
        return cyc_add(SPR_P0, 2 * n);
    endfunction

endpackage

// File: rtl/vicii_sprite_dma_if.sv
// rtl/vicii_sprite_dma_if.sv - memory bus between sprite DMA and the VIC-II address/data path
interface vicii_sprite_dma_if;

    logic [13:0] ao;
    logic        own;
    logic        ba_n;
    logic [7:0]  di;

    modport master (
        output ao,
        output own,
        output ba_n,
        input  di
    );

    modport slave (
        input  ao,
        input  own,
        input  ba_n,
        output di
    );

endinterface

// File: rtl/vicii_sprite_ctr.sv
// rtl/vicii_sprite_ctr.sv - per-sprite MC/MCBASE/MP/expand/DMA state driven by decoded strobes
module vicii_sprite_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       on_evt,
    input  logic       ld_evt,
    input  logic       adv_evt,
    input  logic       chk_evt,
    input  logic       p_evt,
    input  logic       s_evt,
    input  logic       me,
    input  logic       mye,
    input  logic       y_match,
    input  logic [7:0] di,
    output logic [5:0] mc,
    output logic [7:0] mp,
    output logic       dma,
    output logic       dma_nxt
);

    logic [5:0] mcbase;
    logic       expf;
    logic       turn_on;
    logic       turn_off;

    assign turn_on  = on_evt && me && !dma && y_match;
    assign turn_off = chk_evt && (mcbase == 6'd63);

    // Exposed so the BA register can open the window on the turn-on edge itself.
    always_comb begin
        dma_nxt = dma;
        if (turn_on) begin
            dma_nxt = 1'b1;
        end else if (turn_off) begin
            dma_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dma    <= 1'b0;
            expf   <= 1'b1;
            mc     <= 6'd63;
            mcbase <= 6'd63;
            mp     <= 8'd0;
        end else if (ce) begin
            dma <= dma_nxt;
            if (p_evt) begin
                mp <= di;
            end
            if (ld_evt) begin
                mc <= mcbase;
            end else if (s_evt && dma) begin
                mc <= mc + 6'd1;
            end
            if (on_evt) begin
                expf <= turn_on ? !mye : (mye ? !expf : 1'b1);
            end
            if (turn_on) begin
                mcbase <= 6'd0;
            end else if (adv_evt && expf) begin
                mcbase <= mc;
            end
        end
    end

endmodule

// File: rtl/vicii_sprite_dma.sv
// rtl/vicii_sprite_dma.sv - sprite DMA scheduler: slot decode, address/own/load mux, BA generation
module vicii_sprite_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [5:0]  cycle,
    input  logic        phi,
    input  logic [8:0]  raster,
    input  logic [7:0]  ME,
    input  logic [7:0]  MYE,
    input  logic [63:0] SY,
    input  logic [3:0]  VM,
    vicii_sprite_dma_if.master bus,
    output logic [7:0]  load,
    output logic [1:0]  lbyte,
    output logic [7:0]  dma
);

    import vicii_pkg::*;

    logic             on_evt;
    logic             adv_evt;
    logic             chk_evt;
    logic [5:0]       nxt_cyc;
    logic [NSPR-1:0]  p_acc;
    logic [NSPR-1:0]  s_acc;
    logic [NSPR-1:0]  ld_evt;
    logic [NSPR-1:0]  win_nxt;
    logic [NSPR-1:0]  y_match;
    logic [NSPR-1:0]  dma_nxt;
    logic [1:0]       s_idx [NSPR];
    logic [5:0]       mc    [NSPR];
    logic [7:0]       mp    [NSPR];
    logic [13:0]      ao_c;
    logic             own_c;
    logic             ba_q;
    logic             unused_raster;

    assign unused_raster = raster[8];

    assign on_evt  = (cycle == 6'(SPR_ON)) && phi;
    assign adv_evt = (cycle == 6'(SPR_ADV)) && phi;
    assign chk_evt = (cycle == 6'(SPR_ADV + 1)) && phi;

    // Cycle of the half-cycle that begins at this ce edge.
    assign nxt_cyc = !phi ? cycle :
                     (cycle == 6'(CYCLES_PAL - 1)) ? 6'd0 : cycle + 6'd1;

    for (genvar n = 0; n < NSPR; n++) begin : g_spr
        localparam logic [5:0] S   = spr_slot(n);
        localparam logic [5:0] S1  = cyc_add(int'(S), 1);
        localparam logic [5:0] SM1 = cyc_add(int'(S), -1);
        localparam logic [5:0] SM2 = cyc_add(int'(S), -2);

        assign p_acc[n]   = (cycle == S) && !phi;
        assign s_acc[n]   = ((cycle == S) && phi) || (cycle == S1);
        assign s_idx[n]   = (cycle == S) ? 2'd0 : (phi ? 2'd2 : 2'd1);
        assign ld_evt[n]  = (cycle == SM1) && phi;
        assign win_nxt[n] = (nxt_cyc == SM2) || (nxt_cyc == SM1) ||
                            (nxt_cyc == S)   || (nxt_cyc == S1);
        assign y_match[n] = (SY[8*n +: 8] == raster[7:0]);

        vicii_sprite_ctr u_ctr (
            .clk     (clk),
            .reset   (reset),
            .ce      (ce),
            .on_evt  (on_evt),
            .ld_evt  (ld_evt[n]),
            .adv_evt (adv_evt),
            .chk_evt (chk_evt),
            .p_evt   (p_acc[n]),
            .s_evt   (s_acc[n]),
            .me      (ME[n]),
            .mye     (MYE[n]),
            .y_match (y_match[n]),
            .di      (bus.di),
            .mc      (mc[n]),
            .mp      (mp[n]),
            .dma     (dma[n]),
            .dma_nxt (dma_nxt[n])
        );
    end

    // Slots never overlap, so at most one sprite claims any half-cycle.
    always_comb begin
        ao_c  = IDLE_ADDR;
        own_c = 1'b0;
        load  = '0;
        lbyte = 2'd0;
        for (int n = 0; n < NSPR; n++) begin
            if (p_acc[n]) begin
                ao_c  = {VM, 7'h7F, 3'(n)};
                own_c = 1'b1;
            end else if (s_acc[n] && dma[n]) begin
                ao_c    = {mp[n], mc[n]};
                own_c   = 1'b1;
                load[n] = ce && reset;
                lbyte   = s_idx[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ba_q <= 1'b1;
        end else if (ce) begin
            ba_q <= ~|(win_nxt & dma_nxt);
        end
    end

    assign bus.ao   = ao_c;
    assign bus.own  = own_c;
    assign bus.ba_n = ba_q;

endmodule
